// File: rtl/encap_input_arbiter_if.sv
// Source-side and encapsulator-side signals of the encapsulator input arbiter.
// Sources (ARP=0, PTP=1, NMAC=2) drive the master side; the arbiter is the slave.
interface encap_input_arbiter_if;
    logic        i_arb_en;
    logic        i_req_0, i_req_1, i_req_2;
    logic [34:0] iv_descriptor_0, iv_descriptor_1, iv_descriptor_2;
    logic        o_grant_0, o_grant_1, o_grant_2;
    logic [8:0]  iv_data_0, iv_data_1, iv_data_2;
    logic        i_data_wr_0, i_data_wr_1, i_data_wr_2;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [34:0] ov_descriptor;
    logic [15:0] ov_drop_cnt;
    logic [7:0]  ov_timeout_cnt;

    modport slave (
        input  i_arb_en, i_req_0, i_req_1, i_req_2,
               iv_descriptor_0, iv_descriptor_1, iv_descriptor_2,
               iv_data_0, iv_data_1, iv_data_2,
               i_data_wr_0, i_data_wr_1, i_data_wr_2,
        output o_grant_0, o_grant_1, o_grant_2,
               ov_data, o_data_wr, ov_descriptor, ov_drop_cnt, ov_timeout_cnt
    );

    modport master (
        output i_arb_en, i_req_0, i_req_1, i_req_2,
               iv_descriptor_0, iv_descriptor_1, iv_descriptor_2,
               iv_data_0, iv_data_1, iv_data_2,
               i_data_wr_0, i_data_wr_1, i_data_wr_2,
        input  o_grant_0, o_grant_1, o_grant_2,
               ov_data, o_data_wr, ov_descriptor, ov_drop_cnt, ov_timeout_cnt
    );
endinterface

// File: rtl/encap_input_arbiter.sv
// Round-robin arbiter muxing three framed byte sources into one encapsulator
// stream, with start timeout, inter-frame gap and drop/timeout statistics.
module encap_input_arbiter #(
    parameter int unsigned GAP_CYCLES    = 24,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    encap_input_arbiter_if.slave bus
);
    localparam int NUM_SRC = 3;
    localparam int GW      = $clog2(GAP_CYCLES + 2);
    localparam int TW      = $clog2(START_TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, GRANT_WAIT, TRANS, GAP} state_t;

    logic [NUM_SRC-1:0]        req, wr;
    logic [NUM_SRC-1:0][8:0]   data;
    logic [NUM_SRC-1:0][34:0]  desc;

    assign req  = {bus.i_req_2, bus.i_req_1, bus.i_req_0};
    assign wr   = {bus.i_data_wr_2, bus.i_data_wr_1, bus.i_data_wr_0};
    assign data = {bus.iv_data_2, bus.iv_data_1, bus.iv_data_0};
    assign desc = {bus.iv_descriptor_2, bus.iv_descriptor_1, bus.iv_descriptor_0};

    state_t             state;
    logic [1:0]         sel, last;
    logic [34:0]        desc_lat;
    logic [GW-1:0]      gap_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic [NUM_SRC-1:0] grant;
    logic [8:0]         out_data;
    logic               out_wr;
    logic [34:0]        out_desc;
    logic [15:0]        drop_cnt;
    logic [7:0]         tmo_total;

    assign bus.o_grant_0      = grant[0];
    assign bus.o_grant_1      = grant[1];
    assign bus.o_grant_2      = grant[2];
    assign bus.ov_data        = out_data;
    assign bus.o_data_wr      = out_wr;
    assign bus.ov_descriptor  = out_desc;
    assign bus.ov_drop_cnt    = drop_cnt;
    assign bus.ov_timeout_cnt = tmo_total;

    logic [8:0]         sel_data;
    logic               fwd;
    logic [NUM_SRC-1:0] drop;
    logic [1:0]         drop_sum;
    logic [16:0]        drop_nxt;
    logic [1:0]         nxt;
    logic               nxt_vld;
    logic [2:0]         cand;

    always_comb begin
        sel_data = data[sel];
        fwd      = wr[sel] && ((state == GRANT_WAIT && sel_data[8]) || state == TRANS);
        // anything written that is not forwarded is a drop, granted source included
        drop     = wr;
        if (fwd) drop[sel] = 1'b0;
        drop_sum = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
        drop_nxt = {1'b0, drop_cnt} + {15'd0, drop_sum};
        // scan downward so the source closest after the last grant wins
        nxt      = last;
        nxt_vld  = 1'b0;
        cand     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, last} + 3'(k);
            if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
            if (req[cand[1:0]]) begin
                nxt     = cand[1:0];
                nxt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            last      <= 2'd2;
            desc_lat  <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            grant     <= '0;
            out_data  <= '0;
            out_wr    <= 1'b0;
            out_desc  <= '0;
            drop_cnt  <= '0;
            tmo_total <= '0;
        end else begin
            grant    <= '0;
            out_wr   <= fwd;
            if (fwd) out_data <= sel_data;
            drop_cnt <= drop_nxt[16] ? 16'hFFFF : drop_nxt[15:0];
            case (state)
                IDLE: if (bus.i_arb_en && nxt_vld) begin
                    grant    <= NUM_SRC'(1) << nxt;
                    sel      <= nxt;
                    last     <= nxt;
                    desc_lat <= desc[nxt];
                    tmo_cnt  <= '0;
                    state    <= GRANT_WAIT;
                end
                GRANT_WAIT: begin
                    if (fwd) begin
                        out_desc <= desc_lat;
                        state    <= TRANS;
                    end else if (tmo_cnt == TW'(START_TIMEOUT)) begin
                        if (tmo_total != 8'hFF) tmo_total <= tmo_total + 8'd1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                TRANS: if (fwd && sel_data[8]) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (32'(gap_cnt) + 32'd1 >= GAP_CYCLES) state <= IDLE;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_encap_input_arbiter.sv
// Directed + randomized bench for encap_input_arbiter against a frame-level model.
module tb_encap_input_arbiter;
    localparam int GAP = 24;
    localparam int TMO = 16;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    encap_input_arbiter_if bus();
    encap_input_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

    logic [2:0]  req_v = '0, wr_v = '0;
    logic        arb_en_v = 1'b0;
    logic [8:0]  dat_v [3];
    logic [34:0] desc_v [3];
    assign bus.i_arb_en = arb_en_v;
    assign bus.i_req_0 = req_v[0];  assign bus.i_req_1 = req_v[1];  assign bus.i_req_2 = req_v[2];
    assign bus.i_data_wr_0 = wr_v[0]; assign bus.i_data_wr_1 = wr_v[1]; assign bus.i_data_wr_2 = wr_v[2];
    assign bus.iv_data_0 = dat_v[0]; assign bus.iv_data_1 = dat_v[1]; assign bus.iv_data_2 = dat_v[2];
    assign bus.iv_descriptor_0 = desc_v[0];
    assign bus.iv_descriptor_1 = desc_v[1];
    assign bus.iv_descriptor_2 = desc_v[2];
    wire [2:0] gnt = {bus.o_grant_2, bus.o_grant_1, bus.o_grant_0};

    int checks = 0, errors = 0, cyc = 0, gcount = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { logic [8:0] d; int c; } ob_t;
    ob_t obs_q[$];
    always @(negedge i_clk) begin
        if (bus.o_data_wr) obs_q.push_back('{bus.ov_data, cyc});
        if (|gnt) gcount++;
    end

    // reference model state
    int last = 2, exp_drop = 0, exp_tmo = 0, exp_g = 0, prev_last_out = -1000;
    logic [34:0] exp_desc = '0;
    logic [8:0] eb[$];
    int ec[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic step(); @(posedge i_clk); #1; endtask
    function automatic int sat(input int v, input int m); return (v > m) ? m : v; endfunction
    function automatic int predict(input logic [2:0] m, input int l);
        for (int k = 1; k <= 3; k++) if (m[(l + k) % 3]) return (l + k) % 3;
        return -1;
    endfunction

    task automatic junk(input int g, input bit all);
        for (int s = 0; s < 3; s++)
            if ((all || s != g) && $urandom_range(3) == 0) begin
                wr_v[s] = 1'b1; dat_v[s] = 9'($urandom); exp_drop = sat(exp_drop + 1, 65535);
            end
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 80 && !(|gnt); i++) step();
        chk("grant_seen", 64'(|gnt), 1);
        if (!(|gnt)) finish_now();
        for (int s = 0; s < 3; s++) if (gnt[s]) g = s;
    endtask

    task automatic check_frame();
        chk("frm_len", obs_q.size(), eb.size());
        for (int i = 0; i < eb.size() && i < obs_q.size(); i++) begin
            chk("byte_data", obs_q[i].d, eb[i]);
            chk("byte_lat", obs_q[i].c, ec[i]);
        end
        if (obs_q.size() > 0) begin
            chk("gap_ok", 64'((obs_q[0].c - prev_last_out - 1) >= GAP), 1);
            prev_last_out = obs_q[obs_q.size()-1].c;
        end
        chk("desc", bus.ov_descriptor, exp_desc);
        chk("drop_cnt", bus.ov_drop_cnt, exp_drop);
        chk("tmo_cnt", bus.ov_timeout_cnt, exp_tmo);
        chk("grant_cnt", gcount, exp_g);
        obs_q.delete(); eb.delete(); ec.delete();
    endtask

    // mode 0 random frame, 1 fixed 3-byte frame, 3 8-byte frame with src0 interfering
    task automatic do_frame(input int g, input int mode);
        logic [8:0] fb[$];
        int n, dly; bit jk, prej, bub;
        if (mode == 1) begin
            fb = '{9'h1FF, 9'h0AA, 9'h1BB}; dly = 1; jk = 0; prej = 0; bub = 0;
        end else begin
            n = (mode == 3) ? 8 : $urandom_range(2, 8);
            fb.push_back({1'b1, 8'($urandom)});
            for (int i = 1; i < n - 1; i++) fb.push_back({1'b0, 8'($urandom)});
            fb.push_back({1'b1, 8'($urandom)});
            dly = (mode == 3) ? 2 : $urandom_range(0, TMO - 1);
            jk = (mode == 0); prej = (mode == 0) && $urandom_range(1); bub = (mode == 0);
        end
        for (int i = 0; i < dly; i++) begin
            wr_v = '0;
            if (jk) junk(g, 0);
            if (prej && $urandom_range(1) == 1) begin
                wr_v[g] = 1'b1; dat_v[g] = {1'b0, 8'($urandom)}; exp_drop = sat(exp_drop + 1, 65535);
            end
            step();
        end
        for (int i = 0; i < fb.size(); i++) begin
            if (i > 0 && ((bub && $urandom_range(3) == 0) || (mode == 3 && i == 4))) begin
                wr_v = '0;
                if (jk) junk(g, 0);
                step();
            end
            wr_v = '0; wr_v[g] = 1'b1; dat_v[g] = fb[i];
            eb.push_back(fb[i]); ec.push_back(cyc + 1);
            if (jk) junk(g, 0);
            if (mode == 3 && i >= 1 && i <= 5) begin
                wr_v[0] = 1'b1; dat_v[0] = 9'($urandom); exp_drop = sat(exp_drop + 1, 65535);
            end
            step();
        end
        arb_en_v = 1'b1;
        for (int i = 0; i < 10; i++) begin wr_v = '0; if (jk) junk(g, 1); step(); end
        wr_v = '0; step(); step();
        check_frame();
    endtask

    // mode 2 = no data after grant (timeout)
    task automatic run_iter(input logic [2:0] next_mask, input int mode, output int g);
        int p;
        wait_grant(g);
        p = predict(req_v, last);
        chk("grant_src", g, p);
        chk("grant_onehot", $countones(gnt), 1);
        last = g; exp_g++; exp_desc = desc_v[g];
        req_v = next_mask;
        for (int s = 0; s < 3; s++) desc_v[s] = 35'({$urandom, $urandom});
        if (mode == 0 || mode == 2) arb_en_v = ($urandom_range(2) != 0);
        if (mode == 2) begin
            for (int i = 0; i <= TMO; i++) begin wr_v = '0; junk(g, 0); step(); end
            wr_v = '0; arb_en_v = 1'b1; exp_tmo = sat(exp_tmo + 1, 255);
            chk("tmo_cnt", bus.ov_timeout_cnt, exp_tmo);
            chk("tmo_no_out", obs_q.size(), 0);
            chk("tmo_drop", bus.ov_drop_cnt, exp_drop);
        end else begin
            do_frame(g, mode);
        end
    endtask

    initial begin
        int g;
        logic [2:0] m;
        for (int s = 0; s < 3; s++) begin dat_v[s] = '0; desc_v[s] = 35'({$urandom, $urandom}); end
        step(); step();
        chk("rst_data", bus.ov_data, 0);
        chk("rst_wr", bus.o_data_wr, 0);
        chk("rst_desc", bus.ov_descriptor, 0);
        chk("rst_drop", bus.ov_drop_cnt, 0);
        chk("rst_tmo", bus.ov_timeout_cnt, 0);
        chk("rst_grant", gnt, 0);

        // all three requesting out of reset: expect 0,1,2,0
        req_v = 3'b111; arb_en_v = 1'b1; i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_iter((i == 3) ? 3'b010 : 3'b111, 0, g);
            chk("startup_order", g, i % 3);
        end
        run_iter(3'b101, 1, g);
        chk("fixed_src1", g, 1);
        run_iter(3'b101, 2, g);
        chk("tmo_src2", g, 2);
        run_iter(3'b100, 0, g);
        chk("after_tmo_src0", g, 0);
        run_iter(3'b111, 3, g);
        chk("interfere_src2", g, 2);

        for (int i = 0; i < 24; i++) begin
            m = (i == 23) ? 3'b000 : 3'($urandom_range(1, 7));
            run_iter(m, ($urandom_range(5) == 0) ? 2 : 0, g);
        end

        // arbitration disabled: no grants
        arb_en_v = 1'b0; req_v = 3'b111;
        repeat (60) step();
        chk("arb_off_grants", gcount, exp_g);
        chk("arb_off_out", obs_q.size(), 0);

        // reset on the 3rd byte of a frame
        req_v = 3'b001; arb_en_v = 1'b1;
        wait_grant(g);
        chk("pre_rst_src", g, predict(3'b001, last));
        for (int i = 0; i < 2; i++) begin
            wr_v = 3'b001; dat_v[0] = {(i == 0), 8'($urandom)}; step();
        end
        wr_v = 3'b001; dat_v[0] = {1'b0, 8'($urandom)};
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_data", bus.ov_data, 0);
        chk("async_wr", bus.o_data_wr, 0);
        chk("async_desc", bus.ov_descriptor, 0);
        chk("async_drop", bus.ov_drop_cnt, 0);
        chk("async_tmo", bus.ov_timeout_cnt, 0);
        chk("async_grant", gnt, 0);
        wr_v = '0; last = 2; exp_drop = 0; exp_tmo = 0; prev_last_out = -1000; exp_g++;
        exp_desc = '0;
        step(); step();
        obs_q.delete();
        i_rst_n = 1'b1;
        run_iter(3'b000, 0, g);
        chk("post_rst_src", g, 0);

        // timeout counter saturation
        req_v = 3'b111; arb_en_v = 1'b1; wr_v = '0;
        for (int i = 0; i < 300; i++) begin
            wait_grant(g);
            exp_tmo = sat(exp_tmo + 1, 255); exp_g++;
            step();
        end
        req_v = '0;
        repeat (25) step();
        chk("tmo_sat", bus.ov_timeout_cnt, exp_tmo);
        chk("tmo_sat_grants", gcount, exp_g);
        chk("tmo_sat_out", obs_q.size(), 0);

        // drop counter: three sources per cycle, then saturation
        arb_en_v = 1'b0; wr_v = 3'b111;
        for (int i = 0; i < 21000; i++) begin
            for (int s = 0; s < 3; s++) dat_v[s] = 9'($urandom);
            step(); exp_drop = sat(exp_drop + 3, 65535);
        end
        chk("drop_multi", bus.ov_drop_cnt, exp_drop);
        for (int i = 0; i < 900; i++) begin step(); exp_drop = sat(exp_drop + 3, 65535); end
        chk("drop_sat", bus.ov_drop_cnt, exp_drop);
        chk("drop_sat_val", bus.ov_drop_cnt, 16'hFFFF);
        wr_v = '0;
        step();
        finish_now();
    end
endmodule

// File: doc/encap_input_arbiter.md
ENCAP_INPUT_ARBITER -- requirements
Module: encap_input_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 24, idle cycles inserted after each frame's last byte so the downstream encapsulator can emit its header and trailer and return to idle.
REQ-002 Parameter START_TIMEOUT, default 16, maximum cycles from grant to the granted source's first byte.
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_arb_en  in  1  1 = arbitration enabled; 0 = no new grants; a frame in flight completes.
REQ-006 i_req_0/1/2  in  1 each  source has a complete frame ready; 0 = ARP, 1 = PTP, 2 = NMAC report.
REQ-007 iv_descriptor_0/1/2  in  35 each  {rx timestamp[34:16], ethertype[15:0]}; valid while i_req_x is high.
REQ-008 o_grant_0/1/2  out  1 each  one-cycle grant pulse.
REQ-009 iv_data_0/1/2  in  9 each  byte stream; bit8 = 1 on the first byte and on the last byte.
REQ-010 i_data_wr_0/1/2  in  1 each  byte valid.
REQ-011 ov_data  out  9  muxed byte stream toward the encapsulator.
REQ-012 o_data_wr  out  1  output byte valid.
REQ-013 ov_descriptor  out  35  descriptor of the current frame, held constant from the frame's first output byte until the next grant.
REQ-014 ov_drop_cnt  out  16  count of dropped bytes, saturating.
REQ-015 ov_timeout_cnt  out  8  count of grant timeouts, saturating.

Function
REQ-016 FSM states: IDLE, GRANT_WAIT, TRANS, GAP.
REQ-017 IDLE, with i_arb_en = 1 and any i_req_x = 1: select a source round-robin, pulse o_grant_x for 1 cycle, latch iv_descriptor_x, go to GRANT_WAIT.
REQ-018 Round-robin order starts at the index after the last granted source (last-grant pointer resets to 2, so source 0 wins first); the pointer updates only on a grant.
REQ-019 GRANT_WAIT, granted i_data_wr_x = 1 with bit8 = 1: forward the byte, go to TRANS.
REQ-020 GRANT_WAIT, granted byte with bit8 = 0: drop it, increment the drop counter, stay in GRANT_WAIT.
REQ-021 GRANT_WAIT with no first byte within START_TIMEOUT cycles after the grant pulse: increment ov_timeout_cnt, go to IDLE without any output.
REQ-022 TRANS: forward every granted byte; the first subsequent byte with bit8 = 1 is the last byte; forward it and go to GAP.
REQ-023 Minimum frame length is 2 bytes.
REQ-024 Output is registered: a byte accepted in cycle N appears on ov_data/o_data_wr in cycle N+1; bubbles (i_data_wr low) pass through with o_data_wr = 0.
REQ-025 ov_descriptor updates on the same edge that launches the frame's first output byte.
REQ-026 GAP: count GAP_CYCLES cycles with o_data_wr = 0, then go to IDLE; GAP_CYCLES = 0 returns to IDLE on the next cycle.
REQ-027 A grant is never issued in GRANT_WAIT, TRANS or GAP.
REQ-028 Any i_data_wr_y = 1 from a non-granted source, or in IDLE or GAP: drop the byte and increment ov_drop_cnt by 1 per byte.
REQ-029 Drops from several sources in the same cycle add their total count to ov_drop_cnt; saturate at 16'hFFFF.
REQ-030 ov_timeout_cnt saturates at 8'hFF.
REQ-031 i_arb_en deasserted in GRANT_WAIT, TRANS or GAP does not abort the current sequence.
REQ-032 Requests are level-sensitive; a source may hold i_req_x high across frames and is regranted only by round-robin order.

Reset
REQ-033 Asynchronous assertion of i_rst_n = 0 at any time, including mid-frame, forces: state IDLE, all o_grant_x = 0, ov_data = 0, o_data_wr = 0, ov_descriptor = 0, ov_drop_cnt = 0, ov_timeout_cnt = 0, round-robin pointer = 2, gap/timeout counters = 0.
REQ-034 After release no partial frame is resumed; the first grant requires a fresh request.

Verification
REQ-035 All three requests high at reset release, arb_en = 1 -> grants in order 0, 1, 2, 0; each frame is separated on o_data_wr by at least 24 idle cycles.
REQ-036 Source 1 granted, sends 0x1FF, 0x0AA, 0x1BB -> ov_data = 0x1FF, 0x0AA, 0x1BB, each one cycle after input, then GAP; ov_descriptor = the source 1 descriptor.
REQ-037 Grant to source 2 with no data for 16 cycles -> ov_timeout_cnt = 1, return to IDLE, no output bytes, next grant goes to source 0.
REQ-038 Source 0 writes 5 bytes while source 2's frame is in TRANS -> ov_drop_cnt = 5; source 2 frame is intact.
REQ-039 Reset asserted on the 3rd byte of a frame -> all outputs 0 immediately; after release with source 0 requesting, source 0 is granted and its frame is forwarded cleanly.
REQ-040 Frame with a bubble cycle mid-stream -> output shows the same bubble, no drop counted.
